regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 124 ++++++++++++
 tb/tb_regfile_sb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and registered read ports.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data forwarded to reads (write-first).
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  rd_data,
    input  logic [AW-1:0]    rd,
    input  logic             wen,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             ren,
    output logic [XLEN-1:0]  o1,
    output logic [XLEN-1:0]  o2,
    input  logic             alloc,
    input  logic [AW-1:0]    alloc_rd,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;
    logic [XLEN-1:0]  rd1_val;
    logic [XLEN-1:0]  rd2_val;
    logic             wr_hit;
    logic             alloc_hit;

    assign wr_hit    = wen && (rd != '0);
    assign alloc_hit = alloc && (alloc_rd != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[rd] <= rd_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] rs);
        logic [XLEN-1:0] val;
        val = '0;
        if (rs != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (rs == rd)) begin
                val = rd_data;
            end else begin
                val = regs[rs];
            end
`else
            val = regs[rs];
`endif
        end
        return val;
    endfunction

    always_comb begin
        rd1_val = read_port(rs1);
        rd2_val = read_port(rs2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o1 <= '0;
            o2 <= '0;
        end else if (ren) begin
            o1 <= rd1_val;
            o2 <= rd2_val;
        end
    end

    // Clear on write-back first, then set on allocate so a newer producer wins.
    always_comb begin
        busy_next = busy_q;
        if (wr_hit) begin
            busy_next[rd] = 1'b0;
        end
        if (alloc_hit) begin
            busy_next[alloc_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

    function automatic logic busy_of(input logic [AW-1:0] rs);
        logic b;
        b = 1'b0;
        if (rs != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (rs == rd)) begin
                b = alloc_hit && (alloc_rd == rs);
            end else begin
                b = busy_q[rs];
            end
`else
            b = busy_q[rs];
`endif
        end
        return b;
    endfunction

    // Gated by rst_n so the bypass path cannot report busy while in reset.
    always_comb begin
        rs1_busy = rst_n && busy_of(rs1);
        rs2_busy = rst_n && busy_of(rs2);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, parameter variant,
// asynchronous reset sequence and randomized run against a behavioural model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_data = '0;
    logic [4:0]  rd = '0;
    logic        wen = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        ren = 1'b0;
    logic [31:0] o1;
    logic [31:0] o2;
    logic        alloc = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy_vec;

    logic [15:0] p_rd_data = '0;
    logic [2:0]  p_rd = '0;
    logic        p_wen = 1'b0;
    logic [2:0]  p_rs1 = '0;
    logic [2:0]  p_rs2 = '0;
    logic        p_ren = 1'b0;
    logic [15:0] p_o1;
    logic [15:0] p_o2;
    logic        p_alloc = 1'b0;
    logic [2:0]  p_alloc_rd = '0;
    logic        p_rs1_busy;
    logic        p_rs2_busy;
    logic [7:0]  p_busy_vec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .rd_data(rd_data), .rd(rd), .wen(wen),
        .rs1(rs1), .rs2(rs2), .ren(ren), .o1(o1), .o2(o2),
        .alloc(alloc), .alloc_rd(alloc_rd), .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy), .busy_vec(busy_vec)
    );

    regfile_sb #(.XLEN(16), .NREGS(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .rd_data(p_rd_data), .rd(p_rd), .wen(p_wen),
        .rs1(p_rs1), .rs2(p_rs2), .ren(p_ren), .o1(p_o1), .o2(p_o2),
        .alloc(p_alloc), .alloc_rd(p_alloc_rd), .rs1_busy(p_rs1_busy),
        .rs2_busy(p_rs2_busy), .busy_vec(p_busy_vec)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        ren;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        alloc;
        logic [4:0]  alloc_rd;
        logic        exp_b1;
        logic        exp_b2;
        logic [31:0] exp_o1;
        logic [31:0] exp_o2;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs[14];

    // Behavioural reference: architectural registers, pending bits, read outputs.
    logic [31:0] mreg [32];
    logic        mbusy [32];
    logic [31:0] mo1;
    logic [31:0] mo2;

    function automatic vec_t mk(input logic w, input int r, input logic [31:0] d,
                                input logic re, input int a, input int b,
                                input logic al, input int ar,
                                input logic eb1, input logic eb2,
                                input logic [31:0] eo1, input logic [31:0] eo2,
                                input logic [31:0] ebusy);
        vec_t v;
        v.wen = w; v.rd = 5'(r); v.wdata = d; v.ren = re;
        v.rs1 = 5'(a); v.rs2 = 5'(b); v.alloc = al; v.alloc_rd = 5'(ar);
        v.exp_b1 = eb1; v.exp_b2 = eb2; v.exp_o1 = eo1; v.exp_o2 = eo2;
        v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        wen = v.wen; rd = v.rd; rd_data = v.wdata; ren = v.ren;
        rs1 = v.rs1; rs2 = v.rs2; alloc = v.alloc; alloc_rd = v.alloc_rd;
        #1;
        checkOutput($sformatf("vec%0d rs1_busy", idx), 64'(rs1_busy), 64'(v.exp_b1));
        checkOutput($sformatf("vec%0d rs2_busy", idx), 64'(rs2_busy), 64'(v.exp_b2));
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d o1", idx), 64'(o1), 64'(v.exp_o1));
        checkOutput($sformatf("vec%0d o2", idx), 64'(o2), 64'(v.exp_o2));
        checkOutput($sformatf("vec%0d busy_vec", idx), 64'(busy_vec), 64'(v.exp_busy));
    endtask

    function automatic logic model_busy(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        if (BYP && wen && rd == rs) return alloc && alloc_rd == rs;
        return mbusy[rs];
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (BYP && wen && rd == rs) return rd_data;
        return mreg[rs];
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = '0;
            mbusy[i] = 1'b0;
        end
        mo1 = '0;
        mo2 = '0;
    endtask

    task automatic model_edge();
        logic [31:0] n1;
        logic [31:0] n2;
        n1 = model_read(rs1);
        n2 = model_read(rs2);
        if (ren) begin
            mo1 = n1;
            mo2 = n2;
        end
        if (wen && rd != 0) begin
            mreg[rd] = rd_data;
            mbusy[rd] = 1'b0;
        end
        if (alloc && alloc_rd != 0) mbusy[alloc_rd] = 1'b1;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic idle_inputs();
        wen = 1'b0; ren = 1'b0; alloc = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0; alloc_rd = '0; rd_data = '0;
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        vecs[2]  = mk(1, 3, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0, 1, 3, 3, 0, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0, 0, 4, 4, 0, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 32'h0);
        vecs[5]  = mk(1, 7, 32'h11, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 32'h0);
        vecs[6]  = mk(1, 7, 32'h22, 1, 7, 7, 0, 0, 0, 0,
                      BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 32'h0);
        vecs[7]  = mk(0, 0, 32'h0, 1, 7, 3, 0, 0, 0, 0, 32'h22, 32'h1234_5678, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0, 0, 9, 0, 1, 9, 0, 0, 32'h22, 32'h1234_5678, 32'h200);
        vecs[9]  = mk(0, 0, 32'h0, 0, 9, 9, 0, 0, 1, 1, 32'h22, 32'h1234_5678, 32'h200);
        vecs[10] = mk(1, 9, 32'h99, 0, 9, 9, 1, 9, 1, 1, 32'h22, 32'h1234_5678, 32'h200);
        vecs[11] = mk(1, 9, 32'hAB, 0, 9, 9, 0, 0, !BYP, !BYP, 32'h22, 32'h1234_5678, 32'h0);
        vecs[12] = mk(1, 3, 32'h55, 1, 3, 5, 1, 5, 0, 0,
                      BYP ? 32'h55 : 32'h1234_5678, 32'h0, 32'h20);
        vecs[13] = mk(0, 0, 32'h0, 1, 9, 3, 0, 0, 0, 0, 32'hAB, 32'h55, 32'h20);

        // Power-on reset
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset o1", 64'(o1), 64'h0);
        checkOutput("reset o2", 64'(o2), 64'h0);
        checkOutput("reset busy_vec", 64'(busy_vec), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

        // Reduced-parameter instance
        @(negedge clk);
        idle_inputs();
        p_wen = 1'b1; p_rd = 3'd7; p_rd_data = 16'hA5A5;
        p_alloc = 1'b1; p_alloc_rd = 3'd3;
        @(negedge clk);
        p_wen = 1'b0; p_alloc = 1'b0; p_ren = 1'b1; p_rs1 = 3'd0; p_rs2 = 3'd7;
        #1;
        checkOutput("small rs1_busy x0", 64'(p_rs1_busy), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("small o2", 64'(p_o2), 64'hA5A5);
        checkOutput("small o1", 64'(p_o1), 64'h0);
        checkOutput("small busy_vec", 64'(p_busy_vec), 64'h08);
        @(negedge clk);
        p_ren = 1'b0;

        // Asynchronous reset asserted mid-cycle
        wen = 1'b1; rd = 5'd5; rd_data = 32'hDEAD_BEEF; alloc = 1'b1; alloc_rd = 5'd6;
        @(negedge clk);
        wen = 1'b0; alloc = 1'b0; ren = 1'b1; rs1 = 5'd5; rs2 = 5'd5;
        @(posedge clk);
        #1;
        checkOutput("pre-reset o1", 64'(o1), 64'hDEAD_BEEF);
        checkOutput("pre-reset busy_vec", 64'(busy_vec), 64'h40);
        #2;
        rs1 = 5'd6;
        wen = 1'b1; rd = 5'd5; rd_data = 32'h1234; alloc = 1'b1; alloc_rd = 5'd7;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset o1", 64'(o1), 64'h0);
        checkOutput("async reset o2", 64'(o2), 64'h0);
        checkOutput("async reset busy_vec", 64'(busy_vec), 64'h0);
        checkOutput("async reset rs1_busy", 64'(rs1_busy), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("held reset busy_vec", 64'(busy_vec), 64'h0);
        checkOutput("held reset o1", 64'(o1), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wen = 1'b0; alloc = 1'b0; ren = 1'b1; rs1 = 5'd5; rs2 = 5'd6;
        @(posedge clk);
        #1;
        checkOutput("post-reset read x5", 64'(o1), 64'h0);
        checkOutput("post-reset busy_vec", 64'(busy_vec), 64'h0);
        model_clear();

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            wen = 1'($urandom_range(0, 1));
            rd = pick_addr();
            rd_data = $urandom;
            ren = 1'($urandom_range(0, 1));
            rs1 = pick_addr();
            rs2 = ($urandom_range(0, 4) == 0) ? rs1 : pick_addr();
            alloc = 1'($urandom_range(0, 1));
            alloc_rd = ($urandom_range(0, 3) == 0) ? rd : pick_addr();
            #1;
            checkOutput("rand rs1_busy", 64'(rs1_busy), 64'(model_busy(rs1)));
            checkOutput("rand rs2_busy", 64'(rs2_busy), 64'(model_busy(rs2)));
            @(posedge clk);
            model_edge();
            #1;
            checkOutput("rand o1", 64'(o1), 64'(mo1));
            checkOutput("rand o2", 64'(o2), 64'(mo2));
            checkOutput("rand busy_vec", 64'(busy_vec), 64'(model_busy_vec()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
